// File: rtl/iic_reg_bank.sv
// -----------------------------------------------------------------------------
// iic_reg_bank
//   Register bank that sits behind the byte-level interface of iic_slave and
//   drives CH PWM outputs.
//
//   Register map (NREG = CH+2):
//     0..CH-1 : duty[i]  R/W, low PWM_W bits stored, read back zero-extended
//     CH      : ctrl     R/W, bit0 = en, bit1 = inv, other bits read 0
//     CH+1    : id       RO, returns ID
//     >= NREG : reads 8'h00, writes ignored, pointer sticks
//
//   Ports:
//     CLK      : single clock, rising edge
//     RST      : asynchronous active-high reset
//     rx_valid : byte_tc from the slave, rising edge = rx_data holds a byte
//     rx_data  : received byte
//     rd_req   : read_req from the slave, rising edge = next byte wanted
//     stop     : STOP flag from the slave, rising edge = end of transaction
//     tx_data  : registered byte for the slave to transmit
//     pwm      : registered PWM outputs, one per channel
// -----------------------------------------------------------------------------

// Protocol invariants of the bank, kept beside the design they describe.
module iic_reg_bank_chk #(
    parameter int PWM_W = 8
) (
    input logic             CLK,
    input logic             RST,
    input logic             rx_ev_s,
    input logic             rd_ev_s,
    input logic             stop_ev_s,
    input logic [7:0]       tx_data_r,
    input logic [PWM_W-1:0] cnt_r
);
    localparam logic [PWM_W-1:0] CNT_MAX = {{(PWM_W-1){1'b1}}, 1'b0};

    // Priority resolution must never let two events act in one cycle.
    a_one_event: assert property (@(posedge CLK) disable iff (RST)
        $onehot0({rx_ev_s, rd_ev_s, stop_ev_s}));

    // The PWM counter never reaches the all-ones value.
    a_cnt_range: assert property (@(posedge CLK) disable iff (RST)
        cnt_r <= CNT_MAX);

    // The transmit byte only changes in response to a read event.
    a_tx_hold: assert property (@(posedge CLK) disable iff (RST)
        !$past(rd_ev_s) |-> $stable(tx_data_r));
endmodule

module iic_reg_bank #(
    parameter int         CH    = 4,
    parameter int         PWM_W = 8,
    parameter logic [7:0] ID    = 8'hA5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rd_req,
    input  logic          stop,
    output logic [7:0]    tx_data,
    output logic [CH-1:0] pwm
);
    localparam logic [7:0]       CTRL_ADDR = 8'(CH);
    localparam logic [7:0]       ID_ADDR   = 8'(CH + 1);
    localparam logic [7:0]       NREG      = 8'(CH + 2);
    // Counter runs 0 .. 2^PWM_W-2, so a full-scale duty is constantly high.
    localparam logic [PWM_W-1:0] CNT_MAX   = {{(PWM_W-1){1'b1}}, 1'b0};

    // Input history for edge detection
    logic             rx_valid_r;
    logic             rd_req_r;
    logic             stop_r;

    // Decoded single-cycle events
    logic             rx_ev_s;
    logic             rd_ev_s;
    logic             stop_ev_s;

    // Transaction state
    logic             addressed_r;
    logic [7:0]       ptr_r;

    // Register file
    logic [PWM_W-1:0] duty_r [CH];
    logic [1:0]       ctrl_r;
    logic [7:0]       tx_data_r;

    // Write/read decode
    logic             wr_en_s;
    logic [CH-1:0]    duty_we_s;
    logic             ctrl_we_s;
    logic [7:0]       duty_rd_s;
    logic [7:0]       rd_val_s;

    // PWM core
    logic [PWM_W-1:0] cnt_r;
    logic             wrap_s;
    logic [PWM_W-1:0] act_r [CH];
    logic [CH-1:0]    pwm_nxt_s;
    logic [CH-1:0]    pwm_r;

    // Pointer advance: wrap after the last register, stick once out of map.
    function automatic logic [7:0] ptr_advance(input logic [7:0] p);
        logic [7:0] n;
        if (p == ID_ADDR) begin
            n = 8'h00;
        end else if (p >= NREG) begin
            n = p;
        end else begin
            n = p + 8'd1;
        end
        return n;
    endfunction

    // Input history; left out of reset on purpose so that it keeps tracking
    // the inputs while RST is high and a level already high at release is
    // not mistaken for a fresh edge.
    always_ff @(posedge CLK) begin
        rx_valid_r <= rx_valid;
        rd_req_r   <= rd_req;
        stop_r     <= stop;
    end

    // Rising-edge events with fixed priority rx > rd > stop.
    always_comb begin
        rx_ev_s   = rx_valid & ~rx_valid_r;
        rd_ev_s   = rd_req & ~rd_req_r & ~rx_ev_s;
        stop_ev_s = stop & ~stop_r & ~rx_ev_s & ~rd_ev_s;
    end

    // Write strobes: a data byte only writes once the address byte is in.
    always_comb begin
        duty_we_s = '0;
        wr_en_s   = rx_ev_s & addressed_r;
        ctrl_we_s = wr_en_s & (ptr_r == CTRL_ADDR);
        for (int i = 0; i < CH; i++) begin
            duty_we_s[i] = wr_en_s & (ptr_r == 8'(i));
        end
    end

    // Duty read-back, zero-extended to a byte.
    always_comb begin
        duty_rd_s = 8'h00;
        for (int i = 0; i < CH; i++) begin
            duty_rd_s = duty_rd_s | ((ptr_r == 8'(i)) ? 8'(duty_r[i]) : 8'h00);
        end
    end

    // Read multiplexer over the whole map; out-of-map reads return zero.
    always_comb begin
        rd_val_s = 8'h00;
        if (ptr_r < CTRL_ADDR) begin
            rd_val_s = duty_rd_s;
        end else if (ptr_r == CTRL_ADDR) begin
            rd_val_s = {6'b000000, ctrl_r};
        end else if (ptr_r == ID_ADDR) begin
            rd_val_s = ID;
        end else begin
            rd_val_s = 8'h00;
        end
    end

    // Address/pointer tracking across a transaction; ptr survives a STOP.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_r       <= 8'h00;
            addressed_r <= 1'b0;
        end else if (rx_ev_s) begin
            if (!addressed_r) begin
                ptr_r       <= rx_data;
                addressed_r <= 1'b1;
            end else begin
                ptr_r <= ptr_advance(ptr_r);
            end
        end else if (rd_ev_s) begin
            ptr_r <= ptr_advance(ptr_r);
        end else if (stop_ev_s) begin
            addressed_r <= 1'b0;
        end
    end

    // Duty and control registers; id and out-of-map writes fall through.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < CH; i++) begin
                duty_r[i] <= '0;
            end
            ctrl_r <= 2'b00;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (duty_we_s[i]) begin
                    duty_r[i] <= rx_data[PWM_W-1:0];
                end
            end
            if (ctrl_we_s) begin
                ctrl_r <= rx_data[1:0];
            end
        end
    end

    // Transmit byte, held until the next read event.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_data_r <= 8'h00;
        end else if (rd_ev_s) begin
            tx_data_r <= rd_val_s;
        end
    end

    assign wrap_s = (cnt_r == CNT_MAX);

    // Free-running PWM period counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= '0;
        end else if (wrap_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Shadow duty: only taken over as the counter returns to zero, so a
    // period in progress is never cut short or stretched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < CH; i++) begin
                act_r[i] <= '0;
            end
        end else if (wrap_s) begin
            for (int i = 0; i < CH; i++) begin
                act_r[i] <= duty_r[i];
            end
        end
    end

    // Compare stage; en/inv act directly without shadowing.
    always_comb begin
        pwm_nxt_s = '0;
        for (int i = 0; i < CH; i++) begin
            pwm_nxt_s[i] = ctrl_r[0] ? ((cnt_r < act_r[i]) ^ ctrl_r[1]) : ctrl_r[1];
        end
    end

    // Registered PWM outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_r <= '0;
        end else begin
            pwm_r <= pwm_nxt_s;
        end
    end

    assign tx_data = tx_data_r;
    assign pwm     = pwm_r;

    iic_reg_bank_chk #(
        .PWM_W(PWM_W)
    ) u_chk (
        .CLK       (CLK),
        .RST       (RST),
        .rx_ev_s   (rx_ev_s),
        .rd_ev_s   (rd_ev_s),
        .stop_ev_s (stop_ev_s),
        .tx_data_r (tx_data_r),
        .cnt_r     (cnt_r)
    );
endmodule

// File: tb/tb_iic_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_iic_reg_bank
//   Self-checking bench for iic_reg_bank (CH=4, PWM_W=8). A transaction-level
//   model of the register map and pointer predicts every read; PWM outputs are
//   checked over whole periods against the duty/ctrl values the model holds.
// -----------------------------------------------------------------------------
module tb_iic_reg_bank;
    localparam int         CH    = 4;
    localparam int         PWM_W = 8;
    localparam int         NREG  = CH + 2;
    localparam int         PER   = (1 << PWM_W) - 1;
    localparam logic [7:0] ID    = 8'hA5;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          rd_req   = 1'b0;
    logic          stop     = 1'b0;
    logic [7:0]    tx_data;
    logic [CH-1:0] pwm;

    int total = 0;
    int bad   = 0;
    int cyc;

    // Reference model state
    logic [7:0] m_duty [CH];
    logic [1:0] m_ctrl;
    int         m_ptr;
    bit         m_addressed;

    // Results of the last PWM window
    int meas_hi  [CH];
    int meas_mis [CH];
    int meas_exp [CH];

    iic_reg_bank #(
        .CH   (CH),
        .PWM_W(PWM_W),
        .ID   (ID)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rd_req  (rd_req),
        .stop    (stop),
        .tx_data (tx_data),
        .pwm     (pwm)
    );

    always #5 CLK = ~CLK;

    // Cycles since reset release; the PWM phase is this modulo the period.
    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) m_duty[i] = 8'h00;
        m_ctrl      = 2'b00;
        m_ptr       = 0;
        m_addressed = 1'b0;
    endfunction

    function automatic int model_adv(input int p);
        if (p == NREG - 1) return 0;
        if (p >= NREG)     return p;
        return p + 1;
    endfunction

    function automatic logic [7:0] model_read(input int p);
        if (p < CH)      return m_duty[p];
        if (p == CH)     return {6'd0, m_ctrl};
        if (p == CH + 1) return ID;
        return 8'h00;
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        if (!m_addressed) begin
            m_ptr       = b;
            m_addressed = 1'b1;
        end else begin
            if (m_ptr < CH)       m_duty[m_ptr] = b & 8'((1 << PWM_W) - 1);
            else if (m_ptr == CH) m_ctrl = b[1:0];
            m_ptr = model_adv(m_ptr);
        end
    endfunction

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        @(negedge CLK);
        model_rx(b);
    endtask

    task automatic send_stop();
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        @(negedge CLK);
        m_addressed = 1'b0;
    endtask

    task automatic send_rd(output logic [7:0] got);
        rd_req = 1'b1;
        @(negedge CLK);
        got    = tx_data;
        rd_req = 1'b0;
        @(negedge CLK);
        m_ptr = model_adv(m_ptr);
    endtask

    // Observe one full period starting at a boundary; expectations come from
    // the model's duty/ctrl at the start of the window.
    task automatic measure(input bit skip);
        logic [7:0] d [CH];
        bit         en, inv;
        logic       expb;
        int         lim;
        if (skip) @(negedge CLK);
        while (cyc % PER != 1) @(negedge CLK);
        for (int i = 0; i < CH; i++) begin
            d[i] = m_duty[i];
            meas_hi[i]  = 0;
            meas_mis[i] = 0;
        end
        en  = m_ctrl[0];
        inv = m_ctrl[1];
        for (int k = 0; k < PER; k++) begin
            for (int i = 0; i < CH; i++) begin
                expb = en ? (((k < int'(d[i])) ? 1'b1 : 1'b0) ^ inv) : inv;
                if (pwm[i] !== expb) meas_mis[i]++;
                if (pwm[i] === 1'b1) meas_hi[i]++;
            end
            @(negedge CLK);
        end
        for (int i = 0; i < CH; i++) begin
            lim = (int'(d[i]) < PER) ? int'(d[i]) : PER;
            if (!en) meas_exp[i] = inv ? PER : 0;
            else     meas_exp[i] = inv ? PER - lim : lim;
        end
    endtask

    task automatic test_reset();
        model_reset();
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset tx_data: got %02h expected 00", tx_data);
        end
        total++;
        if (pwm !== '0) begin
            bad++;
            $display("FAIL reset pwm: got %b expected 0", pwm);
        end
        measure(1'b1);
        for (int i = 0; i < CH; i++) begin
            total++;
            if (meas_hi[i] !== meas_exp[i] || meas_mis[i] != 0) begin
                bad++;
                $display("FAIL reset pwm%0d: high %0d (wrong cycles %0d) expected high %0d", i, meas_hi[i], meas_mis[i], meas_exp[i]);
            end
        end
    endtask

    task automatic test_write_pwm();
        send_rx(8'h00);
        send_rx(8'h40);
        send_rx(8'h80);
        send_stop();
        send_rx(8'h04);
        send_rx(8'h01);
        send_stop();
        measure(1'b1);
        for (int i = 0; i < CH; i++) begin
            total++;
            if (meas_hi[i] !== meas_exp[i] || meas_mis[i] != 0) begin
                bad++;
                $display("FAIL write_pwm pwm%0d: high %0d (wrong cycles %0d) expected high %0d", i, meas_hi[i], meas_mis[i], meas_exp[i]);
            end
        end
    endtask

    task automatic test_readback();
        logic [7:0] got, exp;
        send_rx(8'h04);
        send_rx(8'h03);
        send_stop();
        for (int n = 0; n < 6; n++) begin
            exp = model_read(m_ptr);
            send_rd(got);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL readback rd%0d: got %02h expected %02h", n, got, exp);
            end
        end
        measure(1'b1);
        for (int i = 0; i < CH; i++) begin
            total++;
            if (meas_hi[i] !== meas_exp[i] || meas_mis[i] != 0) begin
                bad++;
                $display("FAIL inverted pwm%0d: high %0d (wrong cycles %0d) expected high %0d", i, meas_hi[i], meas_mis[i], meas_exp[i]);
            end
        end
    endtask

    task automatic test_id_oob();
        logic [7:0] got, exp;
        send_rx(8'h05);
        send_rx(8'hFF);
        send_stop();
        send_rx(8'h07);
        send_rx(8'h12);
        for (int n = 0; n < 2; n++) begin
            exp = model_read(m_ptr);
            send_rd(got);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL oob rd%0d: got %02h expected %02h", n, got, exp);
            end
        end
        send_stop();
        send_rx(8'h05);
        send_stop();
        exp = model_read(m_ptr);
        send_rd(got);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL id readback: got %02h expected %02h", got, exp);
        end
    endtask

    task automatic test_mid_period();
        send_rx(8'h04);
        send_rx(8'h01);
        send_stop();
        send_rx(8'h00);
        send_rx(8'h40);
        send_stop();
        fork
            measure(1'b1);
            begin
                @(negedge CLK);
                while (cyc % PER != 1) @(negedge CLK);
                while (cyc % PER != 20) @(negedge CLK);
                send_rx(8'h00);
                send_rx(8'h10);
                send_stop();
            end
        join
        for (int i = 0; i < CH; i++) begin
            total++;
            if (meas_hi[i] !== meas_exp[i] || meas_mis[i] != 0) begin
                bad++;
                $display("FAIL mid_old pwm%0d: high %0d (wrong cycles %0d) expected high %0d", i, meas_hi[i], meas_mis[i], meas_exp[i]);
            end
        end
        measure(1'b0);
        for (int i = 0; i < CH; i++) begin
            total++;
            if (meas_hi[i] !== meas_exp[i] || meas_mis[i] != 0) begin
                bad++;
                $display("FAIL mid_new pwm%0d: high %0d (wrong cycles %0d) expected high %0d", i, meas_hi[i], meas_mis[i], meas_exp[i]);
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] x, z, got, exp;
        x = 8'($urandom);
        z = 8'($urandom);
        send_stop();
        send_rx(8'h02);
        rx_data  = x;
        rx_valid = 1'b1;
        stop     = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        stop     = 1'b0;
        @(negedge CLK);
        model_rx(x);
        send_rx(z);
        send_stop();
        send_rx(8'h02);
        send_stop();
        for (int n = 0; n < 2; n++) begin
            exp = model_read(m_ptr);
            send_rd(got);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL priority rd%0d: got %02h expected %02h", n, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        int n;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                send_rx(8'($urandom_range(0, 7)));
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) send_rx(8'($urandom));
                send_stop();
            end else begin
                n = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) begin
                    exp = model_read(m_ptr);
                    send_rd(got);
                    total++;
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL random it%0d rd%0d: got %02h expected %02h", it, j, got, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_pwm_bounds();
        logic [1:0] modes [3];
        modes[0] = 2'b01;
        modes[1] = 2'b11;
        modes[2] = 2'b10;
        send_rx(8'h00);
        send_rx(8'h00);
        send_rx(8'hFF);
        send_rx(8'($urandom));
        send_rx(8'($urandom));
        send_stop();
        for (int m = 0; m < 3; m++) begin
            send_rx(8'h04);
            send_rx({6'd0, modes[m]});
            send_stop();
            measure(1'b1);
            for (int i = 0; i < CH; i++) begin
                total++;
                if (meas_hi[i] !== meas_exp[i] || meas_mis[i] != 0) begin
                    bad++;
                    $display("FAIL bounds mode%0d pwm%0d: high %0d (wrong cycles %0d) expected high %0d", m, i, meas_hi[i], meas_mis[i], meas_exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        send_stop();
        send_rx(8'h01);
        // rx_valid goes high while reset is held and stays high after release.
        RST      = 1'b1;
        rx_data  = 8'h03;
        rx_valid = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        total++;
        if (tx_data !== 8'h00 || pwm !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs: tx %02h pwm %b expected 00 and 0", tx_data, pwm);
        end
        repeat (2) @(negedge CLK);
        rx_valid = 1'b0;
        @(negedge CLK);
        send_rx(8'h04);
        send_rx(8'h01);
        send_stop();
        send_rx(8'h00);
        send_stop();
        for (int n = 0; n < CH; n++) begin
            exp = model_read(m_ptr);
            send_rd(got);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_mid duty%0d: got %02h expected %02h", n, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_pwm();
        test_readback();
        test_id_oob();
        test_mid_period();
        test_priority();
        test_random();
        test_pwm_bounds();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
